// File: rtl/pipe_shifter_if.sv
// rtl/pipe_shifter_if.sv - operand/result handshake bundle for pipe_shifter
interface pipe_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [AW-1:0]    in_amount;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_op, in_amount, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_amount, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - STAGES-deep pipelined barrel shifter (SLL/SRL/SRA, ROTR with PIPE_SHIFTER_ROTATE_EN)
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    pipe_shifter_if.slave bus
);
    localparam int LOG = $clog2(WIDTH);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [1:0]        op_q   [STAGES];
    logic [1:0]        op_d   [STAGES];
    logic [LOG-1:0]    amt_q  [STAGES];
    logic [LOG-1:0]    amt_d  [STAGES];
    logic [STAGES-1:0] sign_q, sign_d;

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_sign;
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [1:0]        src_op   [STAGES];
    logic [LOG-1:0]    src_amt  [STAGES];

    logic advance;

    // Stage s applies amount bit b when floor(b*STAGES/LOG) == s, as fixed shifts of 2^b.
    function automatic logic [WIDTH-1:0] shift_stage(
        input int             s,
        input logic [1:0]     op,
        input logic [LOG-1:0] amt,
        input logic           sign,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int b = 0; b < LOG; b++) begin
            if (((b * STAGES) / LOG) == s && amt[b]) begin
                case (op)
                    2'b00:   r = r << (1 << b);
                    2'b01:   r = r >> (1 << b);
                    2'b10:   r = (r >> (1 << b)) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> (1 << b)));
`ifdef PIPE_SHIFTER_ROTATE_EN
                    default: r = (r >> (1 << b)) | (r << (WIDTH - (1 << b)));
`else
                    default: r = r;
`endif
                endcase
            end
        end
        return r;
    endfunction

    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_src
        if (s == 0) begin : g_head
            assign src_v[s]    = bus.in_valid;
            assign src_op[s]   = bus.in_op;
            assign src_amt[s]  = bus.in_amount;
            assign src_sign[s] = bus.in_data[WIDTH-1];
            assign src_data[s] = bus.in_data;
        end else begin : g_tail
            assign src_v[s]    = vld_q[s-1];
            assign src_op[s]   = op_q[s-1];
            assign src_amt[s]  = amt_q[s-1];
            assign src_sign[s] = sign_q[s-1];
            assign src_data[s] = data_q[s-1];
        end
    end

    // Data and sideband only load for a real operation so a bubble leaves out_data untouched.
    always_comb begin
        vld_d  = vld_q;
        sign_d = sign_q;
        for (int s = 0; s < STAGES; s++) begin
            data_d[s] = data_q[s];
            op_d[s]   = op_q[s];
            amt_d[s]  = amt_q[s];
            if (advance) begin
                vld_d[s] = src_v[s];
                if (src_v[s]) begin
                    data_d[s] = shift_stage(s, src_op[s], src_amt[s], src_sign[s], src_data[s]);
                    op_d[s]   = src_op[s];
                    amt_d[s]  = src_amt[s];
                    sign_d[s] = src_sign[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            sign_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                op_q[s]   <= '0;
                amt_q[s]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            sign_q <= sign_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
                op_q[s]   <= op_d[s];
                amt_q[s]  <= amt_d[s];
            end
        end
    end
endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - randomized scoreboard bench for pipe_shifter (WIDTH=32, STAGES=2)
module tb_pipe_shifter;
    localparam int W   = 32;
    localparam int STG = 2;

    logic clk;
    logic reset;

    pipe_shifter_if #(.WIDTH(W)) bus ();

    pipe_shifter #(.WIDTH(W), .STAGES(STG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_out_cyc = -1;
    bit last_in_fire = 1'b0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift semantics from the operation definitions, written with plain SV operators.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [4:0] amt, input logic [W-1:0] d);
        case (op)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return $signed(d) >>> amt;
`ifdef PIPE_SHIFTER_ROTATE_EN
            default: return (amt == 0) ? d : ((d >> amt) | (d << (W - amt)));
`else
            default: return d;
`endif
        endcase
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        logic in_fire, out_fire;
        #1;
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_fire) begin
                got_q.push_back(bus.out_data);
                last_out_cyc = cyc;
                check_eq("out_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("out_data_order", bus.out_data, exp_q.pop_front());
            end
            if (in_fire) exp_q.push_back(ref_model(bus.in_op, bus.in_amount, bus.in_data));
        end
        last_in_fire = in_fire && !reset;
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_wait(input string tag, input logic [1:0] op, input logic [4:0] amt,
                             input logic [W-1:0] d, input logic [W-1:0] exp);
        int t0, n0, lat;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_amount = amt;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        t0 = cyc;
        n0 = got_q.size();
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8 && got_q.size() == n0; i++) tick();
        lat = (got_q.size() > n0) ? (last_out_cyc - t0) : -1;
        check_eq({tag, "_latency"}, lat, STG);
        if (got_q.size() > n0) check_eq({tag, "_data"}, got_q[$], exp);
        else check_eq({tag, "_data_missing"}, got_q.size(), n0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit hold;
        logic [W-1:0] last_got;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_amount = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        tick();

        send_wait("sra_neg", 2'b10, 5'd4, 32'h8000_0000, 32'hF800_0000);
        send_wait("srl", 2'b01, 5'd4, 32'h8000_0000, 32'h0800_0000);
        send_wait("sll31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
        send_wait("sll0", 2'b00, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
`ifdef PIPE_SHIFTER_ROTATE_EN
        send_wait("rotr1", 2'b11, 5'd1, 32'h0000_0001, 32'h8000_0000);
`else
        send_wait("op11_pass", 2'b11, 5'd1, 32'h0000_0001, 32'h0000_0001);
`endif
        send_wait("sra_amt0", 2'b10, 5'd0, 32'h8123_4567, 32'h8123_4567);

        // Back-to-back with a stalled consumer.
        n0 = got_q.size();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b00;
        bus.in_amount = 5'd4;
        bus.in_data   = 32'h1;
        tick();
        bus.in_data = 32'h2;
        tick();
        bus.in_data = 32'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_in_ready", bus.in_ready, 0);
            check_eq("stall_out_valid", bus.out_valid, 1);
            check_eq("stall_out_data", bus.out_data, 32'h10);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check_eq("stall_count", got_q.size() - n0, 3);
        if (got_q.size() - n0 == 3) begin
            check_eq("stall_r0", got_q[n0], 32'h10);
            check_eq("stall_r1", got_q[n0+1], 32'h20);
            check_eq("stall_r2", got_q[n0+2], 32'h30);
        end

        // Reset with two in flight plus a simultaneous input.
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b00;
        bus.in_amount = 5'd1;
        bus.in_data   = 32'h5;
        tick();
        bus.in_data = 32'h6;
        tick();
        reset = 1'b1;
        bus.in_data = 32'h7;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("flush_out_valid", bus.out_valid, 0);
        check_eq("flush_out_data", bus.out_data, 0);
        check_eq("flush_in_ready", bus.in_ready, 1);
        n0 = got_q.size();
        send_wait("post_rst", 2'b01, 5'd3, 32'h0000_0F00, 32'h0000_01E0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("post_rst_count", got_q.size() - n0, 1);

        // Randomized traffic with random back-pressure; source holds while stalled.
        for (int i = 0; i < 600; i++) begin
            hold = bus.in_valid && !last_in_fire;
            if (!hold) begin
                int r;
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_op    = 2'($urandom_range(0, 3));
                bus.in_data  = $urandom;
                r = $urandom_range(0, 9);
                bus.in_amount = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check_eq("drain_empty", exp_q.size(), 0);
        last_got = (got_q.size() != 0) ? got_q[$] : '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        #1;
        check_eq("idle_out_valid", bus.out_valid, 0);
        check_eq("idle_out_data_hold", bus.out_data, last_got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
